light_bar: RTL and testbench
============================

# light_bar

Parametrised N-position light bar: exactly one light is lit, and single-cycle left/right move events step it one position. It supersedes the per-cell light element, with configurable length, start position, saturate-with-win or wrap mode, and an optional built-in input edge detector. It sits between the debounced player key inputs and the LED driver in the light game datapath.

## Interface

Parameters:
- N, 9, number of light positions (3..32)
- START, N/2, lit position after reset or restart (0..N-1)
- WRAP, 0, 0 = saturate and declare a winner at the ends; 1 = wrap around, never win

Ports:
- Clock  input  1  system clock; all state on rising edge
- Reset  input  1  asynchronous, active-low reset
- restart  input  1  synchronous clear to START, leaves any win state
- left  input  1  move request toward index N-1
- right  input  1  move request toward index 0
- lights  output  N  one-hot; bit i lit when position = i
- pos  output  $clog2(N)  current position index
- win_left  output  1  held high in WIN_L
- win_right  output  1  held high in WIN_R
- moved  output  1  one-cycle pulse on each accepted move

## Operation

- FSM states: PLAY, WIN_L, WIN_R. All outputs are registered.
- Reset value of every output: pos = START, lights = 1<<START, win_left = 0, win_right = 0, moved = 0, state = PLAY.
- Priority per cycle: restart > move.
  - restart: pos = START, state = PLAY, moved = 0.
- PLAY, effective left only:
  - pos < N-1: pos+1, moved = 1.
  - pos = N-1, WRAP=0: go to WIN_L; pos holds; moved = 0.
  - pos = N-1, WRAP=1: pos = 0; moved = 1.
- PLAY, effective right only: the mirror case.
  - pos > 0: pos-1, moved = 1.
  - pos = 0, WRAP=0: go to WIN_R; pos holds; moved = 0.
  - pos = 0, WRAP=1: pos = N-1; moved = 1.
- Left and right in the same cycle cancel: no move, moved = 0.
- WIN_L / WIN_R: all moves are ignored, lights hold, and the win flag stays high until restart or Reset.
- pos arithmetic is unsigned, $clog2(N) bits. Wrap is an explicit compare against N-1 or 0, never a natural binary overflow, so non-power-of-two N is correct.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of Clock.

## Timing

- A move sampled at rising edge k is visible on lights/pos/moved after edge k. Input-to-output latency is 1 cycle.
- Win flags rise after the same edge that samples the end-stop move.
- restart takes effect at the next edge; the flags are low after that edge.
- With edge detection enabled (see Configuration):
  - An input held high produces exactly one move, on the first edge where it is sampled high.
  - It needs at least one low sample before it can move again.
  - Latency is unchanged.
- The edge-detect history registers reset to 1, so an input already high when Reset releases does not cause a move.

## Configuration

- Macro: LIGHT_BAR_EDGE_DETECT_EN.
- Defined: left and right each pass through a rising-edge detector, so one key press gives one move.
- Undefined: left and right are taken as pre-formed single-cycle pulses, and every cycle sampled high is a move. No history registers are built.

## Structure

- Package light_bar_pkg holds:
  - typedef enum logic [1:0] {PLAY, WIN_L, WIN_R} light_bar_state_t
  - the function that converts a position index to a one-hot lights vector
- One sub-module, edge_pulse:
  - a one-bit registered rising-edge detector with asynchronous active-low reset to 1
  - instantiated twice under LIGHT_BAR_EDGE_DETECT_EN

## Test plan

- Reset low mid-run with N=9 -> lights=9'b000010000, pos=4, flags and moved 0 immediately. Release with left held high (EDGE_DETECT_EN) -> no move.
- WRAP=0, N=9: five left pulses from pos=4 -> pos 5,6,7,8, then WIN_L with win_left=1. A further right pulse -> no change. restart -> pos=4, win_left=0.
- WRAP=0: five right pulses from pos=4 -> pos reaches 0, then win_right=1 and moved=0 on the win cycle.
- WRAP=1, N=5, START=4: one left -> pos=0, moved=1. One right -> pos=4. Never any win flag.
- left and right high in the same cycle -> pos unchanged, moved=0. restart together with left -> pos=START.
- EDGE_DETECT_EN: left held 10 cycles -> exactly one move. Undefined: left held 3 cycles -> three moves.

Source files
------------

// File: rtl/light_bar_pkg.sv
// Shared types and helpers for the light_bar block.
// Holds the FSM state encoding and the position-to-one-hot conversion.
package light_bar_pkg;

    localparam int MAX_N  = 32;
    localparam int MAX_PW = 5;

    typedef enum logic [1:0] {PLAY, WIN_L, WIN_R} light_bar_state_t;

    // Callers truncate the result to their own bar length.
    function automatic logic [MAX_N-1:0] pos_to_onehot(input logic [MAX_PW-1:0] p);
        return {{(MAX_N-1){1'b0}}, 1'b1} << p;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: q is high for the cycle d is first sampled high after a low sample.
// Latency: combinational from d (history register only); no backpressure.
// History resets to 1 so an input already high at reset release produces no pulse.
module edge_pulse (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic hist;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hist <= 1'b1;
        end else begin
            hist <= d;
        end
    end

    assign q = d & ~hist;

endmodule

// File: rtl/light_bar.sv
// N-position one-hot light bar stepped by left/right move events; saturate-with-win or wrap.
// Latency: 1 cycle from sampled move to lights/pos/moved; no backpressure, inputs always accepted.
// LIGHT_BAR_EDGE_DETECT_EN turns held keys into single moves via edge_pulse.
module light_bar
    import light_bar_pkg::*;
#(
    parameter int N     = 9,
    parameter int START = N / 2,
    parameter int WRAP  = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 restart,
    input  logic                 left,
    input  logic                 right,
    output logic [N-1:0]         lights,
    output logic [$clog2(N)-1:0] pos,
    output logic                 win_left,
    output logic                 win_right,
    output logic                 moved
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST  = PW'(N - 1);
    localparam logic [PW-1:0] FIRST = PW'(START);

    light_bar_state_t state;
    logic             mv_l;
    logic             mv_r;

`ifdef LIGHT_BAR_EDGE_DETECT_EN
    edge_pulse u_left_edge (
        .Clock (Clock),
        .Reset (Reset),
        .d     (left),
        .q     (mv_l)
    );

    edge_pulse u_right_edge (
        .Clock (Clock),
        .Reset (Reset),
        .d     (right),
        .q     (mv_r)
    );
`else
    assign mv_l = left;
    assign mv_r = right;
`endif

    // Ends are explicit compares so non-power-of-two N wraps correctly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= PLAY;
            pos       <= FIRST;
            lights    <= N'(pos_to_onehot(MAX_PW'(FIRST)));
            win_left  <= 1'b0;
            win_right <= 1'b0;
            moved     <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (restart) begin
                state     <= PLAY;
                pos       <= FIRST;
                lights    <= N'(pos_to_onehot(MAX_PW'(FIRST)));
                win_left  <= 1'b0;
                win_right <= 1'b0;
            end else if (state == PLAY && (mv_l ^ mv_r)) begin
                if (mv_l) begin
                    if (pos != LAST) begin
                        pos    <= pos + 1'b1;
                        lights <= N'(pos_to_onehot(MAX_PW'(pos + 1'b1)));
                        moved  <= 1'b1;
                    end else if (WRAP != 0) begin
                        pos    <= '0;
                        lights <= N'(pos_to_onehot(MAX_PW'(0)));
                        moved  <= 1'b1;
                    end else begin
                        state    <= WIN_L;
                        win_left <= 1'b1;
                    end
                end else begin
                    if (pos != '0) begin
                        pos    <= pos - 1'b1;
                        lights <= N'(pos_to_onehot(MAX_PW'(pos - 1'b1)));
                        moved  <= 1'b1;
                    end else if (WRAP != 0) begin
                        pos    <= LAST;
                        lights <= N'(pos_to_onehot(MAX_PW'(LAST)));
                        moved  <= 1'b1;
                    end else begin
                        state     <= WIN_R;
                        win_right <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_light_bar.sv
// Self-checking bench for light_bar: saturating N=9 instance and wrapping N=5/START=4 instance
// driven by shared stimulus and checked each cycle against a behavioural model.
module tb_light_bar;

`ifdef LIGHT_BAR_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic       restart;
    logic       left;
    logic       right;

    logic [8:0] lights_a;
    logic [3:0] pos_a;
    logic       wl_a, wr_a, mv_a;
    logic [4:0] lights_b;
    logic [2:0] pos_b;
    logic       wl_b, wr_b, mv_b;

    int errors = 0;
    int checks = 0;

    light_bar #(.N(9), .START(4), .WRAP(0)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .restart   (restart),
        .left      (left),
        .right     (right),
        .lights    (lights_a),
        .pos       (pos_a),
        .win_left  (wl_a),
        .win_right (wr_a),
        .moved     (mv_a)
    );

    light_bar #(.N(5), .START(4), .WRAP(1)) dut_w (
        .Clock     (Clock),
        .Reset     (Reset),
        .restart   (restart),
        .left      (left),
        .right     (right),
        .lights    (lights_b),
        .pos       (pos_b),
        .win_left  (wl_b),
        .win_right (wr_b),
        .moved     (mv_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = N9 saturating, index 1 = N5 wrapping.
    // mst: 0 playing, 1 left has won, 2 right has won.
    int mn[2]  = '{9, 5};
    int ms[2]  = '{4, 4};
    int mw[2]  = '{0, 1};
    int mp[2];
    int mst[2];
    int mmv[2];
    bit prev_l, prev_r;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                mp[i]  = ms[i];
                mst[i] = 0;
                mmv[i] = 0;
            end
            prev_l = 1'b1;
            prev_r = 1'b1;
        end else begin
            bit el, er;
            el = left  && (!EDGE || !prev_l);
            er = right && (!EDGE || !prev_r);
            prev_l = left;
            prev_r = right;
            for (int i = 0; i < 2; i++) begin
                mmv[i] = 0;
                if (restart) begin
                    mp[i]  = ms[i];
                    mst[i] = 0;
                end else if (mst[i] == 0 && el != er) begin
                    if (el) begin
                        if (mp[i] < mn[i] - 1) begin mp[i]++; mmv[i] = 1; end
                        else if (mw[i] != 0)   begin mp[i] = 0; mmv[i] = 1; end
                        else                   mst[i] = 1;
                    end else begin
                        if (mp[i] > 0)         begin mp[i]--; mmv[i] = 1; end
                        else if (mw[i] != 0)   begin mp[i] = mn[i] - 1; mmv[i] = 1; end
                        else                   mst[i] = 2;
                    end
                end
            end
        end
    end

    always @(negedge Clock) begin
        check("a.pos",    int'(pos_a),    mp[0]);
        check("a.lights", int'(lights_a), 1 << mp[0]);
        check("a.win_l",  int'(wl_a),     int'(mst[0] == 1));
        check("a.win_r",  int'(wr_a),     int'(mst[0] == 2));
        check("a.moved",  int'(mv_a),     mmv[0]);
        check("b.pos",    int'(pos_b),    mp[1]);
        check("b.lights", int'(lights_b), 1 << mp[1]);
        check("b.win",    int'(wl_b | wr_b), 0);
        check("b.moved",  int'(mv_b),     mmv[1]);
    end

    task automatic step(input logic l, input logic r, input logic rs);
        left    = l;
        right   = r;
        restart = rs;
        @(negedge Clock);
    endtask

    task automatic pulse_left();
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        int hold;
        Reset   = 1'b0;
        restart = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        #12;
        check("reset.lights", int'(lights_a), 9'b000010000);
        check("reset.pos",    int'(pos_a), 4);
        check("reset.moved",  int'(mv_a), 0);
        @(negedge Clock);
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        for (int k = 5; k <= 8; k++) begin
            pulse_left();
            check("left.pos",   int'(pos_a), k);
            check("left.moved", int'(mv_a), 1);
            step(1'b0, 1'b0, 1'b0);
        end
        pulse_left();
        check("winl.flag",  int'(wl_a), 1);
        check("winl.pos",   int'(pos_a), 8);
        check("winl.moved", int'(mv_a), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("winl.ignore.pos", int'(pos_a), 8);
        check("winl.hold",       int'(wl_a), 1);
        step(1'b0, 1'b0, 1'b1);
        check("restart.pos",  int'(pos_a), 4);
        check("restart.winl", int'(wl_a), 0);

        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("right.pos", int'(pos_a), 3 - k);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("winr.flag",  int'(wr_a), 1);
        check("winr.moved", int'(mv_a), 0);
        check("winr.pos",   int'(pos_a), 0);
        step(1'b0, 1'b0, 1'b1);

        pulse_left();
        check("wrap.left.pos",   int'(pos_b), 0);
        check("wrap.left.moved", int'(mv_b), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("wrap.right.pos",  int'(pos_b), 4);
        step(1'b0, 1'b0, 1'b0);

        step(1'b1, 1'b1, 1'b0);
        check("both.pos",   int'(pos_a), 4);
        check("both.moved", int'(mv_a), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("restart_left.pos", int'(pos_a), 4);
        step(1'b0, 1'b0, 1'b0);

        hold = EDGE ? 10 : 3;
        cnt  = 0;
        for (int k = 0; k < hold; k++) begin
            step(1'b1, 1'b0, 1'b0);
            cnt += int'(mv_a);
        end
        check("hold.moves", cnt, EDGE ? 1 : 3);
        check("hold.pos",   int'(pos_a), EDGE ? 5 : 7);

        left = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check("midreset.lights", int'(lights_a), 9'b000010000);
        check("midreset.pos",    int'(pos_a), 4);
        check("midreset.flags",  int'(wl_a | wr_a | mv_a), 0);
        #1 Reset = 1'b1;
        @(negedge Clock);
        if (EDGE) begin
            check("release_held.pos",   int'(pos_a), 4);
            check("release_held.moved", int'(mv_a), 0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
